// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame controller: FSM states, serial interface
// output bundle and the idle/reset value of that bundle.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        SFC_IDLE  = 3'd0,
        SFC_LOAD  = 3'd1,
        SFC_START = 3'd2,
        SFC_WR_LO = 3'd3,
        SFC_WR_HI = 3'd4,
        SFC_RD_LO = 3'd5,
        SFC_RD_HI = 3'd6,
        SFC_END   = 3'd7
    } sfc_state_e;

    typedef struct packed {
        logic tclk;
        logic trst;
        logic dq_en;
        logic sr_en;
    } sfc_if_t;

    localparam sfc_if_t SFC_IDLE_OUT = '{tclk: 1'b1, trst: 1'b0, dq_en: 1'b0, sr_en: 1'b0};

endpackage

// File: rtl/sfc_frame_counter.sv
// Frame cycle counter: clear has priority, saturates at FRAME_LEN-1 and flags
// the last cycle of the frame.
module sfc_frame_counter #(
    parameter int FRAME_LEN = 40,
    parameter int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [CW-1:0] cnt_r;

    assign last = (cnt_r == CW'(FRAME_LEN - 1));

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && !last) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: LOAD, START, write pairs, read pairs, END gap.
// Optional SERIAL_FRAME_AUTORESTART_EN: free-running back-to-back frames.
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int FRAME_LEN = 40,
    parameter int WR_MAX    = 8,
    parameter int RD_MAX    = 9,
    localparam int WL_W  = $clog2(WR_MAX + 1),
    localparam int RL_W  = $clog2(RD_MAX + 1),
    localparam int MX    = (WR_MAX > RD_MAX) ? WR_MAX : RD_MAX,
    localparam int IDX_W = (MX > 1) ? $clog2(MX) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WL_W-1:0]  wr_len,
    input  logic [RL_W-1:0]  rd_len,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx,
    output logic             tclk,
    output logic             trst,
    output logic             dq_en,
    output logic             sr_en
);

    localparam int PW = (WL_W > RL_W) ? WL_W : RL_W;
    localparam logic [WL_W-1:0] WR_MAX_L = WL_W'(WR_MAX);
    localparam logic [RL_W-1:0] RD_MAX_L = RL_W'(RD_MAX);

    if (FRAME_LEN < 3 + 2 * WR_MAX + 2 * RD_MAX) begin : g_len_check
        $error("serial_frame_ctrl: FRAME_LEN too short for WR_MAX/RD_MAX");
    end

    sfc_state_e      state_r, state_nx_s;
    logic [PW-1:0]   pair_r, pair_nx_s;
    logic [WL_W-1:0] wr_len_r, wr_len_cl_s;
    logic [RL_W-1:0] rd_len_r, rd_len_cl_s;
    logic            last_s, cnt_clr_s, wr_last_s, rd_last_s;
    sfc_if_t         if_s;

    assign busy      = (state_r != SFC_IDLE);
    assign done      = (state_r == SFC_END) && last_s;
    assign cnt_clr_s = (state_r == SFC_IDLE) || done;
    assign wr_last_s = (pair_r == PW'(wr_len_r) - PW'(1));
    assign rd_last_s = (pair_r == PW'(rd_len_r) - PW'(1));
    assign wr_len_cl_s = (wr_len > WR_MAX_L) ? WR_MAX_L : wr_len;
    assign rd_len_cl_s = (rd_len > RD_MAX_L) ? RD_MAX_L : rd_len;

    sfc_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (busy),
        .last (last_s)
    );

    // State, pair index and latched length registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= SFC_IDLE;
            pair_r   <= {PW{1'b0}};
            wr_len_r <= {WL_W{1'b0}};
            rd_len_r <= {RL_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            pair_r  <= pair_nx_s;
            if ((state_r == SFC_IDLE) && start) begin
                wr_len_r <= wr_len_cl_s;
                rd_len_r <= rd_len_cl_s;
            end else begin
                wr_len_r <= wr_len_r;
                rd_len_r <= rd_len_r;
            end
        end
    end

    // Next-state and pair index logic
    always_comb begin
        state_nx_s = state_r;
        pair_nx_s  = pair_r;
        case (state_r)
            SFC_IDLE: begin
                pair_nx_s = {PW{1'b0}};
                if (start) state_nx_s = SFC_LOAD;
                else       state_nx_s = SFC_IDLE;
            end
            SFC_LOAD:  state_nx_s = SFC_START;
            SFC_START: begin
                pair_nx_s = {PW{1'b0}};
                if (wr_len_r != {WL_W{1'b0}})      state_nx_s = SFC_WR_LO;
                else if (rd_len_r != {RL_W{1'b0}}) state_nx_s = SFC_RD_LO;
                else                               state_nx_s = SFC_END;
            end
            SFC_WR_LO: state_nx_s = SFC_WR_HI;
            SFC_WR_HI: begin
                if (wr_last_s) begin
                    pair_nx_s = {PW{1'b0}};
                    if (rd_len_r != {RL_W{1'b0}}) state_nx_s = SFC_RD_LO;
                    else                          state_nx_s = SFC_END;
                end else begin
                    pair_nx_s  = pair_r + PW'(1);
                    state_nx_s = SFC_WR_LO;
                end
            end
            SFC_RD_LO: state_nx_s = SFC_RD_HI;
            SFC_RD_HI: begin
                if (rd_last_s) begin
                    pair_nx_s  = {PW{1'b0}};
                    state_nx_s = SFC_END;
                end else begin
                    pair_nx_s  = pair_r + PW'(1);
                    state_nx_s = SFC_RD_LO;
                end
            end
            SFC_END: begin
                pair_nx_s = {PW{1'b0}};
                if (last_s) begin
`ifdef SERIAL_FRAME_AUTORESTART_EN
                    state_nx_s = SFC_LOAD;
`else
                    state_nx_s = SFC_IDLE;
`endif
                end else begin
                    state_nx_s = SFC_END;
                end
            end
            default: begin
                pair_nx_s  = {PW{1'b0}};
                state_nx_s = SFC_IDLE;
            end
        endcase
    end

    // Serial interface decode from the state register
    always_comb begin
        if_s    = SFC_IDLE_OUT;
        bit_idx = {IDX_W{1'b0}};
        case (state_r)
            SFC_IDLE, SFC_LOAD: if_s = SFC_IDLE_OUT;
            SFC_START, SFC_END: if_s = '{tclk: 1'b1, trst: 1'b1, dq_en: 1'b0, sr_en: 1'b0};
            SFC_WR_LO: begin
                if_s    = '{tclk: 1'b0, trst: 1'b1, dq_en: 1'b1, sr_en: 1'b1};
                bit_idx = pair_r[IDX_W-1:0];
            end
            SFC_WR_HI: begin
                if_s    = '{tclk: 1'b1, trst: 1'b1, dq_en: 1'b1, sr_en: 1'b0};
                bit_idx = pair_r[IDX_W-1:0];
            end
            SFC_RD_LO: begin
                if_s    = '{tclk: 1'b0, trst: 1'b1, dq_en: 1'b0, sr_en: 1'b1};
                bit_idx = pair_r[IDX_W-1:0];
            end
            SFC_RD_HI: begin
                if_s    = '{tclk: 1'b1, trst: 1'b1, dq_en: 1'b0, sr_en: 1'b0};
                bit_idx = pair_r[IDX_W-1:0];
            end
            default: if_s = SFC_IDLE_OUT;
        endcase
    end

    assign tclk  = if_s.tclk;
    assign trst  = if_s.trst;
    assign dq_en = if_s.dq_en;
    assign sr_en = if_s.sr_en;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl (default build): expected per-cycle
// output vectors are queued when a frame is requested and popped each cycle.
module tb_serial_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] wr_len = 4'd0;
    logic [3:0] rd_len = 4'd0;
    logic       busy, done, tclk, trst, dq_en, sr_en;
    logic [3:0] bit_idx;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [9:0] exp_q[$];

    localparam logic [9:0] IDLE_VEC = 10'b00_1000_0000;

    always #5 clk = ~clk;

    serial_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .wr_len(wr_len), .rd_len(rd_len),
        .busy(busy), .done(done), .bit_idx(bit_idx),
        .tclk(tclk), .trst(trst), .dq_en(dq_en), .sr_en(sr_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy,done,tclk,trst,dq_en,sr_en,bit_idx} for frame cycle k
    function automatic logic [9:0] exp_vec(input int k, input int w, input int r);
        logic b, d, tc, tr, dq, sr;
        logic [3:0] idx;
        int j;
        b = 1'b1; d = 1'b0; tc = 1'b1; tr = 1'b1; dq = 1'b0; sr = 1'b0; idx = 4'd0;
        if (k == 0) begin
            tr = 1'b0;
        end else if (k == 1) begin
            tr = 1'b1;
        end else if (k < 2 + 2 * w) begin
            j = k - 2; idx = 4'(j / 2); dq = 1'b1;
            if (j % 2 == 0) begin tc = 1'b0; sr = 1'b1; end
        end else if (k < 2 + 2 * w + 2 * r) begin
            j = k - 2 - 2 * w; idx = 4'(j / 2);
            if (j % 2 == 0) begin tc = 1'b0; sr = 1'b1; end
        end else begin
            d = (k == 39);
        end
        return {b, d, tc, tr, dq, sr, idx};
    endfunction

    task automatic run_frame(input string tag, input logic [3:0] wr, input logic [3:0] rd,
                             input int stop_k, input bit hold,
                             output int dq_n, output int sr_n, output int tlo_n);
        int w, r;
        logic [9:0] e;
        w = (wr > 4'd8) ? 8 : int'(wr);
        r = (rd > 4'd9) ? 9 : int'(rd);
        for (int k = 0; k < 40; k++) exp_q.push_back(exp_vec(k, w, r));
        dq_n = 0; sr_n = 0; tlo_n = 0;
        wr_len = wr; rd_len = rd; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (hold) begin
                wr_len = 4'd2; rd_len = 4'd1;
                if (k == 39) start = 1'b0;
            end else begin
                start = 1'b0;
            end
            e = exp_q.pop_front();
            check_eq(tag, {22'd0, busy, done, tclk, trst, dq_en, sr_en, bit_idx}, {22'd0, e});
            dq_n += int'(dq_en); sr_n += int'(sr_en); tlo_n += int'(!tclk);
            if (k == stop_k) begin
                rst = 1'b1;
                exp_q.delete();
                break;
            end
        end
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, {22'd0, busy, done, tclk, trst, dq_en, sr_en, bit_idx}, {22'd0, IDLE_VEC});
        rst = 1'b0;
    endtask

    initial begin
        int dq_n, sr_n, tlo_n;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", {22'd0, busy, done, tclk, trst, dq_en, sr_en, bit_idx}, {22'd0, IDLE_VEC});
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame("full", 4'd8, 4'd9, -1, 1'b0, dq_n, sr_n, tlo_n);
        check_eq("full_dq_cnt", 32'(dq_n), 32'd16);
        check_eq("full_sr_cnt", 32'(sr_n), 32'd17);
        check_eq("full_tlo_cnt", 32'(tlo_n), 32'd17);

        run_frame("rd_only", 4'd0, 4'd3, -1, 1'b0, dq_n, sr_n, tlo_n);
        check_eq("rd_only_dq_cnt", 32'(dq_n), 32'd0);

        run_frame("empty", 4'd0, 4'd0, -1, 1'b0, dq_n, sr_n, tlo_n);
        check_eq("empty_tlo_cnt", 32'(tlo_n), 32'd0);

        // k=9 is cnt 9, a WR_HI cycle; reset then back to idle
        run_frame("abort", 4'd8, 4'd9, 9, 1'b0, dq_n, sr_n, tlo_n);
        run_frame("after_abort", 4'd8, 4'd9, -1, 1'b0, dq_n, sr_n, tlo_n);

        run_frame("hold", 4'd5, 4'd2, -1, 1'b1, dq_n, sr_n, tlo_n);
        check_eq("hold_dq_cnt", 32'(dq_n), 32'd10);
        @(posedge clk); #1;
        check_eq("hold_no_restart", {31'd0, busy}, 32'd0);

        run_frame("clamp", 4'd15, 4'd15, -1, 1'b0, dq_n, sr_n, tlo_n);
        check_eq("clamp_dq_cnt", 32'(dq_n), 32'd16);
        check_eq("clamp_sr_cnt", 32'(sr_n), 32'd17);

        run_frame("mixed", 4'd3, 4'd1, -1, 1'b0, dq_n, sr_n, tlo_n);
        check_eq("mixed_sr_cnt", 32'(sr_n), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
